// File: rtl/uart_mmio_pkg.sv
// Shared constants for the uart_mmio register block: register map, bit
// positions and FSM state encodings.
package uart_mmio_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_NOTFULL  = 1;
    localparam int ST_TX_IDLE     = 2;
    localparam int ST_OVERRUN     = 3;

    localparam int CTRL_RX_IE     = 0;
    localparam int CTRL_TXIDLE_IE = 1;
    localparam int CTRL_CLR_OVR   = 7;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_LAUNCH = 2'd1,
        TX_HOLD   = 2'd2,
        TX_WAIT   = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_SKIP = 2'd1
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead head output; push is refused when
// full and pop is ignored when empty, both judged on start-of-cycle state.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == FULL_COUNT);
    assign empty     = (count_r == '0);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// CPU register block for uart_core: bus decode, TX/RX byte FIFOs, the TX
// launcher and RX drain handshakes, and a level interrupt.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] bus_addr,
    input  logic [7:0] bus_wdata,
    input  logic       bus_we,
    input  logic       bus_re,
    output logic [7:0] bus_rdata,
    output logic       irq,
    output logic [7:0] uart_data_tx,
    output logic       uart_have_data_tx,
    input  logic       uart_transmitting,
    input  logic [7:0] uart_data_rx,
    input  logic       uart_have_data_rx,
    output logic       uart_data_rx_ack
);
    tx_state_t  tx_state_r;
    rx_state_t  rx_state_r;
    logic [7:0] rdata_r;
    logic       irq_r;
    logic [7:0] data_tx_r;
    logic       have_data_tx_r;
    logic       rx_ie_r;
    logic       txidle_ie_r;
    logic       overrun_r;

    logic       tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic       rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
    logic [7:0] tx_head_s, rx_head_s;
    logic       ctrl_wr_s, tx_idle_s;
    logic [7:0] status_s, rdata_s;

    assign tx_push_s = bus_we && (bus_addr == REG_DATA);
    assign tx_pop_s  = (tx_state_r == TX_LAUNCH);
    assign rx_push_s = (rx_state_r == RX_IDLE) && uart_have_data_rx && !rx_full_s;
    assign rx_pop_s  = bus_re && (bus_addr == REG_DATA);
    assign ctrl_wr_s = bus_we && (bus_addr == REG_CTRL);
    assign tx_idle_s = tx_empty_s && (tx_state_r == TX_IDLE) && !uart_transmitting;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push_s), .pop(tx_pop_s),
        .din(bus_wdata), .head(tx_head_s), .full(tx_full_s), .empty(tx_empty_s)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push_s), .pop(rx_pop_s),
        .din(uart_data_rx), .head(rx_head_s), .full(rx_full_s), .empty(rx_empty_s)
    );

    // Read-data mux over the register map, built from pre-write state.
    always_comb begin
        status_s                 = 8'h00;
        status_s[ST_RX_NONEMPTY] = !rx_empty_s;
        status_s[ST_TX_NOTFULL]  = !tx_full_s;
        status_s[ST_TX_IDLE]     = tx_idle_s;
        status_s[ST_OVERRUN]     = overrun_r;
        case (bus_addr)
            REG_DATA:   rdata_s = rx_empty_s ? 8'h00 : rx_head_s;
            REG_STATUS: rdata_s = status_s;
            REG_CTRL:   rdata_s = {6'b000000, txidle_ie_r, rx_ie_r};
            default:    rdata_s = 8'h00;
        endcase
    end

    // Registered read data, control bits, sticky overrun and interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r     <= 8'h00;
            rx_ie_r     <= 1'b0;
            txidle_ie_r <= 1'b0;
            overrun_r   <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            if (bus_re) begin
                rdata_r <= rdata_s;
            end
            if (ctrl_wr_s) begin
                rx_ie_r     <= bus_wdata[CTRL_RX_IE];
                txidle_ie_r <= bus_wdata[CTRL_TXIDLE_IE];
            end
            // A byte refused this cycle outranks a simultaneous clear.
            if ((rx_state_r == RX_IDLE) && uart_have_data_rx && rx_full_s) begin
                overrun_r <= 1'b1;
            end else if (ctrl_wr_s && bus_wdata[CTRL_CLR_OVR]) begin
                overrun_r <= 1'b0;
            end
            irq_r <= (rx_ie_r && !rx_empty_s) || (txidle_ie_r && tx_idle_s);
        end
    end

    // TX launcher: one-cycle launch pulse, one HOLD cycle for the core's
    // busy-flag latency, then wait for the frame to finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r     <= TX_IDLE;
            have_data_tx_r <= 1'b0;
            data_tx_r      <= 8'h00;
        end else begin
            have_data_tx_r <= 1'b0;
            case (tx_state_r)
                TX_IDLE: begin
                    if (!tx_empty_s && !uart_transmitting) begin
                        tx_state_r     <= TX_LAUNCH;
                        have_data_tx_r <= 1'b1;
                        data_tx_r      <= tx_head_s;
                    end
                end
                TX_LAUNCH: tx_state_r <= TX_HOLD;
                TX_HOLD:   tx_state_r <= TX_WAIT;
                TX_WAIT: begin
                    if (!uart_transmitting) begin
                        tx_state_r <= TX_IDLE;
                    end
                end
                default: tx_state_r <= TX_IDLE;
            endcase
        end
    end

    // RX drain: after an accepted byte skip one cycle while the core drops
    // its pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r <= RX_IDLE;
        end else begin
            case (rx_state_r)
                RX_IDLE: rx_state_r <= rx_push_s ? RX_SKIP : RX_IDLE;
                RX_SKIP: rx_state_r <= RX_IDLE;
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

    assign bus_rdata         = rdata_r;
    assign irq               = irq_r;
    assign uart_data_tx      = data_tx_r;
    assign uart_have_data_tx = have_data_tx_r;
    assign uart_data_rx_ack  = rx_push_s;

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: a register-access vector table plus
// hand-written TX, RX, overrun, interrupt and reset sequences.
module tb_uart_mmio;

    localparam int FRAME = 20;

    logic       clk;
    logic       rst_n;
    logic [1:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata;
    logic       irq;
    logic [7:0] uart_data_tx;
    logic       uart_have_data_tx;
    logic       uart_transmitting;
    logic [7:0] uart_data_rx;
    logic       uart_have_data_rx;
    logic       uart_data_rx_ack;

    int         n_vec;
    int         n_miss;
    logic       hold_busy;
    int         busy_cnt;
    int         ack_cnt;
    logic [7:0] launch_q [$];

    uart_mmio #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .irq(irq),
        .uart_data_tx(uart_data_tx), .uart_have_data_tx(uart_have_data_tx),
        .uart_transmitting(uart_transmitting), .uart_data_rx(uart_data_rx),
        .uart_have_data_rx(uart_have_data_rx), .uart_data_rx_ack(uart_data_rx_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core TX model: busy rises the cycle after a launch and lasts FRAME cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_cnt <= 0;
        else if (uart_have_data_tx) busy_cnt <= FRAME;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign uart_transmitting = (busy_cnt != 0) || hold_busy;

    always @(posedge clk) begin
        if (rst_n && uart_have_data_tx) launch_q.push_back(uart_data_tx);
        if (rst_n && uart_data_rx_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr = a; bus_wdata = d; bus_we = 1'b1;
        @(negedge clk);
        bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_addr = a; bus_re = 1'b1;
        @(negedge clk);
        bus_re = 1'b0;
        d = bus_rdata;
    endtask

    // Present a byte as the core would; drop it once acked, else leave it pending.
    task automatic rx_byte(input logic [7:0] b, input int budget, output logic acked, output int cyc);
        acked = 1'b0;
        cyc = -1;
        @(negedge clk);
        uart_have_data_rx = 1'b1; uart_data_rx = b;
        for (int i = 0; i < budget && !acked; i++) begin
            #1;
            if (uart_data_rx_ack) begin acked = 1'b1; cyc = i; end
            @(negedge clk);
        end
        if (acked) uart_have_data_rx = 1'b0;
    endtask

    typedef struct {
        logic       we;
        logic       re;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic       chk;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [14];
    logic [7:0] rd;
    logic       acked;
    int         cyc;
    int         acks0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 2'd1, 8'h00, 1'b1, 8'h06};
        vecs[1]  = '{1'b0, 1'b1, 2'd2, 8'h00, 1'b1, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 2'd3, 8'h00, 1'b1, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 2'd0, 8'h00, 1'b1, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 2'd2, 8'h03, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 2'd2, 8'h00, 1'b1, 8'h03};
        vecs[6]  = '{1'b1, 1'b0, 2'd2, 8'hFC, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, 2'd2, 8'h00, 1'b1, 8'h00};
        vecs[8]  = '{1'b1, 1'b1, 2'd2, 8'h02, 1'b1, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 2'd2, 8'h00, 1'b1, 8'h02};
        vecs[10] = '{1'b1, 1'b0, 2'd3, 8'hAA, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 1'b1, 2'd3, 8'h00, 1'b1, 8'h00};
        vecs[12] = '{1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 8'h00};
        vecs[13] = '{1'b0, 1'b1, 2'd2, 8'h00, 1'b1, 8'h00};

        n_vec = 0; n_miss = 0; ack_cnt = 0; hold_busy = 1'b0;
        rst_n = 1'b0; bus_addr = 2'd0; bus_wdata = 8'h00; bus_we = 1'b0; bus_re = 1'b0;
        uart_data_rx = 8'h00; uart_have_data_rx = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset rdata", bus_rdata, 8'h00);
        check("reset irq", irq, 0);
        check("reset data_tx", uart_data_tx, 8'h00);
        check("reset have_tx", uart_have_data_tx, 0);
        check("reset rx_ack", uart_data_rx_ack, 0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus_addr = vecs[i].addr; bus_wdata = vecs[i].wdata;
            bus_we = vecs[i].we; bus_re = vecs[i].re;
            @(negedge clk);
            bus_we = 1'b0; bus_re = 1'b0;
            if (vecs[i].chk) check($sformatf("vec%0d rdata", i), bus_rdata, vecs[i].exp);
        end

        // Basic TX: launch one cycle after the write lands.
        launch_q.delete();
        bus_write(2'd0, 8'h55);
        @(negedge clk);
        check("tx launch pulse", uart_have_data_tx, 1);
        check("tx launch data", uart_data_tx, 8'h55);
        @(negedge clk);
        check("tx pulse width", uart_have_data_tx, 0);
        repeat (2) @(negedge clk);
        bus_read(2'd1, rd);
        check("tx busy status", rd, 8'h02);
        for (int i = 0; i < 100 && uart_transmitting; i++) @(negedge clk);
        check("tx core idle", uart_transmitting, 0);
        @(negedge clk);
        bus_read(2'd1, rd);
        check("tx idle status", rd, 8'h06);
        check("tx launch count", launch_q.size(), 1);

        // TX overflow with the core held busy.
        launch_q.delete();
        hold_busy = 1'b1;
        for (int i = 1; i <= 4; i++) bus_write(2'd0, 8'(i));
        bus_read(2'd1, rd);
        check("tx full status", rd, 8'h00);
        bus_write(2'd0, 8'h05);
        hold_busy = 1'b0;
        for (int i = 0; i < 400 && launch_q.size() < 4; i++) @(negedge clk);
        repeat (60) @(negedge clk);
        check("tx overflow count", launch_q.size(), 4);
        for (int i = 0; i < 4 && i < launch_q.size(); i++)
            check($sformatf("tx overflow byte%0d", i), launch_q[i], i + 1);

        // Basic RX.
        rx_byte(8'hA3, 4, acked, cyc);
        check("rx ack cycle", cyc, 0);
        check("rx ack width", uart_data_rx_ack, 0);
        bus_read(2'd1, rd);
        check("rx status", rd, 8'h07);
        bus_read(2'd0, rd);
        check("rx data", rd, 8'hA3);
        bus_read(2'd1, rd);
        check("rx status empty", rd, 8'h06);

        // RX full and overrun.
        acks0 = ack_cnt;
        for (int i = 0; i < 4; i++) rx_byte(8'h10 + 8'(i), 4, acked, cyc);
        rx_byte(8'h14, 4, acked, cyc);
        check("rx 5th refused", acked, 0);
        check("rx ack total", ack_cnt - acks0, 4);
        bus_read(2'd1, rd);
        check("rx overrun status", rd, 8'h0F);
        bus_read(2'd0, rd);
        check("rx full byte0", rd, 8'h10);
        #1;
        check("rx 5th drained", uart_data_rx_ack, 1);
        @(negedge clk);
        uart_have_data_rx = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus_read(2'd0, rd);
            check($sformatf("rx full byte%0d", i), rd, 8'h10 + i);
        end
        bus_read(2'd1, rd);
        check("rx overrun sticky", rd, 8'h0E);
        bus_write(2'd2, 8'h80);
        bus_read(2'd1, rd);
        check("rx overrun cleared", rd, 8'h06);

        // Interrupts.
        bus_write(2'd2, 8'h01);
        @(negedge clk);
        check("irq rx empty", irq, 0);
        rx_byte(8'h77, 4, acked, cyc);
        @(negedge clk);
        check("irq rx rise", irq, 1);
        bus_read(2'd0, rd);
        check("irq rx data", rd, 8'h77);
        @(negedge clk);
        check("irq rx fall", irq, 0);
        bus_write(2'd2, 8'h02);
        @(negedge clk);
        check("irq txidle", irq, 1);
        bus_write(2'd2, 8'h00);

        // Reset mid-frame with two bytes queued.
        launch_q.delete();
        bus_write(2'd0, 8'hA1);
        bus_write(2'd0, 8'hA2);
        bus_write(2'd0, 8'hA3);
        for (int i = 0; i < 20 && launch_q.size() < 1; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        bus_read(2'd1, rd);
        check("pre-reset status", rd, 8'h02);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset rdata", bus_rdata, 8'h00);
        check("midreset irq", irq, 0);
        check("midreset data_tx", uart_data_tx, 8'h00);
        check("midreset have_tx", uart_have_data_tx, 0);
        check("midreset rx_ack", uart_data_rx_ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("post-reset launches", launch_q.size(), 1);
        bus_read(2'd1, rd);
        check("post-reset status", rd, 8'h06);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
